// File: rtl/fft_pkg.sv
// Shared types and address math for the radix-2 DIT FFT butterfly scheduler.
// Pure package: no latency, no flow control.
// Address records are sized for the largest supported FFT and truncated by users.
package fft_pkg;

  localparam int MAX_LOG2N = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_LOG2N-1:0] addr_a;
    logic [MAX_LOG2N-1:0] addr_b;
  } wb_entry_t;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] addr_a;
    logic [MAX_LOG2N-1:0] addr_b;
  } addr_pair_t;

  // Upper operand is k with a zero inserted at bit s; the lower one sets that bit.
  function automatic addr_pair_t bf_addr(input logic [MAX_LOG2N-1:0] k,
                                         input logic [4:0]           s,
                                         input logic [4:0]           log2n);
    addr_pair_t  pair;
    logic [31:0] span;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] a;
    logic [31:0] mask;
    span        = 32'd1 << s;
    lo          = 32'(k) & (span - 32'd1);
    hi          = (32'(k) >> s) << (s + 5'd1);
    a           = hi | lo;
    mask        = (32'd1 << log2n) - 32'd1;
    pair.addr_a = MAX_LOG2N'(a & mask);
    pair.addr_b = MAX_LOG2N'((a + span) & mask);
    return pair;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly operand and twiddle address generator for stage s, butterfly k.
// Purely combinational, zero latency; no flow control.
// Twiddle stride doubles resolution each stage: (k mod span) << (LOG2N-1-s).
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic [LOG2N-1:0] s,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr
);

  addr_pair_t  pair;
  logic [31:0] lo;
  logic [31:0] sh;
  logic [31:0] tw_full;

  always_comb begin
    pair    = bf_addr(MAX_LOG2N'(k), 5'(s), 5'(LOG2N));
    lo      = 32'(k) & ((32'd1 << s) - 32'd1);
    sh      = 32'(LOG2N - 1) - 32'(s);
    tw_full = lo << sh;
  end

  assign addr_a  = LOG2N'(pair.addr_a);
  assign addr_b  = LOG2N'(pair.addr_b);
  assign tw_addr = (LOG2N-1)'(tw_full);

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, BF_LATENCY drain bubbles per stage.
// Reads 1 cycle after start; write-back strobes trail reads by BF_LATENCY; optional FFT_SCHED_ABORT_EN.
// No backpressure: once started the schedule runs to done (or abort when enabled).
module fft_butterfly_scheduler
  import fft_pkg::*;
#(
  parameter int N_POINTS   = 16,
  parameter int LOG2N      = $clog2(N_POINTS),
  parameter int BF_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FFT_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int HALF = N_POINTS / 2;
  localparam int CW   = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  sched_state_t     state;
  logic [LOG2N-2:0] k;
  logic [LOG2N-1:0] s;
  logic [CW-1:0]    dcnt;
  wb_entry_t        wb_line [BF_LATENCY];

  logic [LOG2N-2:0] k_g;
  logic [LOG2N-1:0] s_g;
  logic [LOG2N-1:0] a_g;
  logic [LOG2N-1:0] b_g;
  logic [LOG2N-2:0] tw_g;
  logic             kill;

`ifdef FFT_SCHED_ABORT_EN
  assign kill = abort && ((state == ISSUE) || (state == DRAIN));
`else
  assign kill = 1'b0;
`endif

  // Addresses are generated for the butterfly issued on the next edge so rd_* can be registered.
  always_comb begin
    s_g = s;
    k_g = k + 1'b1;
    unique case (state)
      IDLE: begin
        s_g = '0;
        k_g = '0;
      end
      DRAIN: begin
        s_g = s + 1'b1;
        k_g = '0;
      end
      default: ;
    endcase
  end

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s       (s_g),
    .k       (k_g),
    .addr_a  (a_g),
    .addr_b  (b_g),
    .tw_addr (tw_g)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      s         <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      for (int i = 0; i < BF_LATENCY; i++) wb_line[i] <= '0;
    end else begin
      done <= 1'b0;
      // The line shifts in every state, so the drain bubbles flush it.
      wb_line[0] <= '{valid: rd_en, addr_a: MAX_LOG2N'(rd_addr_a), addr_b: MAX_LOG2N'(rd_addr_b)};
      for (int i = 1; i < BF_LATENCY; i++) wb_line[i] <= wb_line[i-1];

      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
        rd_en <= 1'b0;
        for (int i = 0; i < BF_LATENCY; i++) wb_line[i] <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state     <= ISSUE;
              s         <= '0;
              k         <= '0;
              busy      <= 1'b1;
              rd_en     <= 1'b1;
              stage     <= s_g;
              rd_addr_a <= a_g;
              rd_addr_b <= b_g;
              tw_addr   <= tw_g;
            end
          end
          ISSUE: begin
            if (k == (LOG2N-1)'(HALF - 1)) begin
              state <= DRAIN;
              k     <= '0;
              dcnt  <= '0;
              rd_en <= 1'b0;
            end else begin
              k         <= k + 1'b1;
              rd_en     <= 1'b1;
              rd_addr_a <= a_g;
              rd_addr_b <= b_g;
              tw_addr   <= tw_g;
            end
          end
          DRAIN: begin
            if (dcnt == CW'(BF_LATENCY - 1)) begin
              if (s < LOG2N'(LOG2N - 1)) begin
                state     <= ISSUE;
                s         <= s + 1'b1;
                k         <= '0;
                rd_en     <= 1'b1;
                stage     <= s_g;
                rd_addr_a <= a_g;
                rd_addr_b <= b_g;
                tw_addr   <= tw_g;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            rd_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en     = wb_line[BF_LATENCY-1].valid;
  assign wr_addr_a = LOG2N'(wb_line[BF_LATENCY-1].addr_a);
  assign wr_addr_b = LOG2N'(wb_line[BF_LATENCY-1].addr_b);

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Bench for fft_butterfly_scheduler: three N=16 instances (latency 1, 2, 5) against a cycle-indexed schedule model.
// Define FFT_SCHED_ABORT_EN to also exercise the abort port.
module tb_fft_butterfly_scheduler;

  localparam int N   = 16;
  localparam int LOG = 4;
  localparam int H   = N / 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort_s;

  always #5 clk = ~clk;

  logic       busy_w  [3];
  logic       done_w  [3];
  logic       rd_en_w [3];
  logic       wr_en_w [3];
  logic [3:0] stage_w [3];
  logic [3:0] rd_a_w  [3];
  logic [3:0] rd_b_w  [3];
  logic [3:0] wr_a_w  [3];
  logic [3:0] wr_b_w  [3];
  logic [2:0] tw_w    [3];

  int checks = 0;
  int errors = 0;

  int          ecount = 0;
  bit          active [3];
  int          e0     [3];
  int          rd_cnt [3];
  int          wr_cnt [3];
  int          pend   [3][16];
  logic [15:0] mask   [3][4];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
    fft_butterfly_scheduler #(.N_POINTS(N), .BF_LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
`ifdef FFT_SCHED_ABORT_EN
      .abort     (abort_s),
`endif
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .stage     (stage_w[g]),
      .rd_en     (rd_en_w[g]),
      .rd_addr_a (rd_a_w[g]),
      .rd_addr_b (rd_b_w[g]),
      .tw_addr   (tw_w[g]),
      .wr_en     (wr_en_w[g]),
      .wr_addr_a (wr_a_w[g]),
      .wr_addr_b (wr_b_w[g])
    );
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 5);
  endfunction

  // Cycle t of a run (start sampled in cycle 0) -> is it a read cycle, and for which stage/butterfly.
  function automatic bit in_read(input int t, input int L, output int j, output int k);
    int p;
    p = H + L;
    j = 0;
    k = 0;
    if (t < 1) return 1'b0;
    j = (t - 1) / p;
    k = (t - 1) % p;
    return (j < LOG) && (k < H);
  endfunction

  function automatic int exp_a(input int j, input int k);
    int span;
    span = 1 << j;
    return (k / span) * 2 * span + (k % span);
  endfunction

  function automatic int exp_tw(input int j, input int k);
    int span;
    span = 1 << j;
    return (k % span) * (H / span);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy",  32'(busy_w[i]),  0);
      chk("rst_done",  32'(done_w[i]),  0);
      chk("rst_rd_en", 32'(rd_en_w[i]), 0);
      chk("rst_wr_en", 32'(wr_en_w[i]), 0);
      chk("rst_stage", 32'(stage_w[i]), 0);
      chk("rst_rd_a",  32'(rd_a_w[i]),  0);
      chk("rst_rd_b",  32'(rd_b_w[i]),  0);
      chk("rst_tw",    32'(tw_w[i]),    0);
      chk("rst_wr_a",  32'(wr_a_w[i]),  0);
      chk("rst_wr_b",  32'(wr_b_w[i]),  0);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int L;
      int D;
      int t;
      int j;
      int k;
      int jw;
      int kw;
      bit er;
      bit ew;
      L  = lat(i);
      D  = 1 + LOG * (H + L);
      t  = active[i] ? (ecount - e0[i] + 1) : -1000;
      er = in_read(t, L, j, k);
      ew = in_read(t - L, L, jw, kw);
      chk("rd_en", 32'(rd_en_w[i]), 32'(er));
      chk("wr_en", 32'(wr_en_w[i]), 32'(ew));
      chk("busy",  32'(busy_w[i]),  32'((t >= 1) && (t <= D - 1)));
      chk("done",  32'(done_w[i]),  32'(t == D));
      if (rd_en_w[i] === 1'b1) rd_cnt[i]++;
      if (wr_en_w[i] === 1'b1) wr_cnt[i]++;
      if (er) begin
        chk("rd_a",  32'(rd_a_w[i]),  exp_a(j, k));
        chk("rd_b",  32'(rd_b_w[i]),  exp_a(j, k) + (1 << j));
        chk("tw",    32'(tw_w[i]),    exp_tw(j, k));
        chk("stage", 32'(stage_w[i]), j);
        chk("hazard_a", 32'(pend[i][rd_a_w[i]] < t), 1);
        chk("hazard_b", 32'(pend[i][rd_b_w[i]] < t), 1);
        pend[i][rd_a_w[i]] = t + L;
        pend[i][rd_b_w[i]] = t + L;
        mask[i][j] = mask[i][j] | (16'd1 << rd_a_w[i]) | (16'd1 << rd_b_w[i]);
        if (i == 1 && j == 1 && k == 3) begin
          chk("s1k3_a",  32'(rd_a_w[i]), 5);
          chk("s1k3_b",  32'(rd_b_w[i]), 7);
          chk("s1k3_tw", 32'(tw_w[i]),   4);
        end
        if (i == 1 && j == 3 && k == 7) begin
          chk("s3k7_a",  32'(rd_a_w[i]), 7);
          chk("s3k7_b",  32'(rd_b_w[i]), 15);
          chk("s3k7_tw", 32'(tw_w[i]),   7);
        end
      end
      if (ew) begin
        chk("wr_a", 32'(wr_a_w[i]), exp_a(jw, kw));
        chk("wr_b", 32'(wr_b_w[i]), exp_a(jw, kw) + (1 << jw));
      end
      if (done_w[i] === 1'b1) chk("done_cycle", t, D);
      if (t == D) begin
        chk("rd_pulses", rd_cnt[i], H * LOG);
        chk("wr_pulses", wr_cnt[i], H * LOG);
        for (int st = 0; st < LOG; st++) chk("stage_cover", 32'(mask[i][st]), 32'hFFFF);
      end
    end
  endtask

  // One clock: update the run model from the inputs sampled at this edge, then check 1 unit later.
  task automatic tick();
    bit st;
    bit ab;
    st = start;
    ab = abort_s;
    @(posedge clk);
    ecount++;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        int D;
        int c;
        D = 1 + LOG * (lat(i) + H);
        c = ecount - e0[i];
        if (active[i] && c >= 1 && c <= D - 1 && ab) begin
          active[i] = 1'b0;
        end else if ((!active[i] || c >= D + 1) && st) begin
          active[i] = 1'b1;
          e0[i]     = ecount;
          rd_cnt[i] = 0;
          wr_cnt[i] = 0;
          for (int a = 0; a < 16; a++) pend[i][a] = -1;
          for (int s = 0; s < LOG; s++) mask[i][s] = '0;
        end
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort_s = 1'b0;
    for (int i = 0; i < 3; i++) active[i] = 1'b0;
    tick();
    tick();
    check_zero();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single full run.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();

    // Asynchronous reset in cycle 5 of a run, then a clean rerun.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 check_zero();
    for (int i = 0; i < 3; i++) active[i] = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (60) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();

    // Start held high: back-to-back runs, each beginning from the IDLE cycle after done.
    start = 1'b1;
    repeat (130) tick();
    start = 1'b0;
    repeat (60) tick();

`ifdef FFT_SCHED_ABORT_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    repeat (20) tick();
    start   = 1'b1;
    abort_s = 1'b1;
    tick();
    start   = 1'b0;
    abort_s = 1'b0;
    repeat (60) tick();
`endif

    // Random start (and abort, when present) traffic.
    repeat (400) begin
      start = ($urandom_range(0, 19) == 0);
`ifdef FFT_SCHED_ABORT_EN
      abort_s = ($urandom_range(0, 39) == 0);
`endif
      tick();
    end
    start   = 1'b0;
    abort_s = 1'b0;
    repeat (60) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_scheduler.md
# fft_butterfly_scheduler

Sequencer for an in-place radix-2 decimation-in-time FFT engine. It walks every stage and butterfly and issues one butterfly per cycle. For each butterfly it drives data-memory read addresses, the twiddle-ROM address, and delayed write-back addresses to the butterfly datapath (complex multiplier plus complex adder/subtractor pair). It inserts drain bubbles between stages so that no stage reads a result before it has been written.

## Interface
- `N_POINTS`, default 16: FFT size; power of two, ≥ 4.
- `LOG2N`, default `$clog2(N_POINTS)`: stage count and address width; derived, not overridden.
- `BF_LATENCY`, default 2: cycles from `rd_en` to the matching `wr_en`. Must be ≥ 1.
- `clk` in 1: rising-edge clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to run one FFT.
- `abort` in 1: cancel the run in progress. Exists only under `FFT_SCHED_ABORT_EN`.
- `busy` out 1: high while the state is ISSUE or DRAIN.
- `done` out 1: one-cycle pulse when the final write-back has completed.
- `stage` out LOG2N: current stage index.
- `rd_en` out 1: read strobe for a butterfly operand pair.
- `rd_addr_a` out LOG2N: address of the upper operand.
- `rd_addr_b` out LOG2N: address of the lower operand.
- `tw_addr` out LOG2N-1: twiddle-ROM index.
- `wr_en` out 1: write-back strobe.
- `wr_addr_a` out LOG2N: write-back address for the upper result.
- `wr_addr_b` out LOG2N: write-back address for the lower result.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start`. This transition also clears stage s = 0 and butterfly counter k = 0.
- `start` is ignored in every state other than IDLE.
- In ISSUE, `rd_en` = 1 every cycle and k increments.
  - When k = N/2−1, the next state is DRAIN and k wraps to 0.
- DRAIN holds `rd_en` = 0 for exactly `BF_LATENCY` cycles.
  - Then, if s < LOG2N−1: s increments and the FSM returns to ISSUE.
  - Otherwise the FSM goes to DONE.
- DONE lasts one cycle with `done` = 1, then returns to IDLE.
- Address generation, with span = 1 << s:
  - `rd_addr_a` = k with a 0 bit inserted at bit position s, i.e. ((k >> s) << (s+1)) | (k & (span−1)).
  - `rd_addr_b` = `rd_addr_a` + span.
  - `tw_addr` = (k & (span−1)) << (LOG2N−1−s).
- Write-back delay line:
  - A shift register of depth `BF_LATENCY` carries {valid, addr_a, addr_b}.
  - `wr_en` and `wr_addr_*` are the output of this line.
  - The delay line keeps shifting in every state, so DRAIN empties it.
- Address and `stage` outputs are don't-care when `rd_en` = 0, but they must hold their last value (no X).
- Reset mid-run returns the FSM to IDLE immediately and clears the delay line. No `done` pulse is produced.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_en`, `wr_en` = 0; `stage`, all address outputs, and the delay line = 0.
- Outputs are registered.
- `start` sampled at cycle 0 gives the first `rd_en` at cycle 1.
- Stage j's reads occupy cycles 1 + j·(N/2+L) through j·(N/2+L) + N/2, where L = `BF_LATENCY`.
- `wr_en` follows each `rd_en` by exactly L cycles.
- `done` rises at cycle 1 + LOG2N·(N/2+L). For N = 16, L = 2 this is cycle 41, and the last `wr_en` is at cycle 40.
- A next-stage read never coincides with or precedes a write-back of the previous stage. The data memory must make a write visible on the following cycle.
- `start` in the DONE cycle is ignored. A new `start` is accepted from the following IDLE cycle.

## Configuration
- Macro: `FFT_SCHED_ABORT_EN`.
- Defined:
  - The `abort` port exists.
  - `abort` = 1 in ISSUE or DRAIN forces IDLE on the next edge, clears the delay line (no further `wr_en`), and suppresses `done`.
  - `abort` in IDLE or DONE has no effect.
  - If `abort` and `start` are both asserted in IDLE, `start` wins.
- Undefined: the port is absent and a run always completes.

## Structure
- Package `fft_pkg` holds:
  - the FSM state enum `sched_state_t`;
  - the write-back record typedef `wb_entry_t` {valid, addr_a, addr_b};
  - the function `bf_addr(k, s, log2n)` that returns the address pair.
- One natural sub-module: `fft_addr_gen`, the combinational address and twiddle computation from (s, k).
- The FSM, counters and delay line stay in the top module.

## Test plan
- Reset mid-ISSUE (N = 16, L = 2, at cycle 5): all outputs go to 0 asynchronously; no `done` pulse; the next `start` runs cleanly.
- Full run (N = 16, L = 2): `start` at cycle 0 gives `done` at cycle 41; 32 `rd_en` and 32 `wr_en` pulses; each stage touches all 16 addresses exactly once.
- Address check (N = 16):
  - stage 1, k = 3 gives a = 5, b = 7, `tw_addr` = 4;
  - stage 3, k = 7 gives a = 7, b = 15, `tw_addr` = 7.
- Hazard check: across all runs, no read at cycle t of an address whose write is pending at cycle ≥ t. Sweep L = 1, 2, 5.
- Start handling: `start` held high throughout a run gives exactly one run. A new run begins the cycle after `done` drops to IDLE.
- Abort (macro on): `abort` at cycle 12 gives `busy` = 0 at 13, no `wr_en` after 12, and no `done`. Repeating with `start` and `abort` together in IDLE starts a run.
